if_fetch_queue: RTL

Parametrised instruction-fetch stage for the five-stage MIPS pipeline. It drives the instruction SRAM, captures returned words into a small prefetch queue, and presents {pc, inst} pairs to ID through a valid/ready handshake. Branch redirects from EX flush the queue and discard any in-flight response. The queue decouples SRAM issue from ID back-pressure, replacing the single-register PC/`ce` fetch stage.

---
 rtl/if_fetch_queue.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch stage for the five-stage MIPS pipeline.  Issues reads to
// the instruction SRAM, captures each returned word together with its PC in
// a small prefetch queue, and hands {pc, inst} pairs to ID.  A branch
// redirect from EX flushes the queue and discards any response in flight.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   br_bus[32:0]       {br_e, br_addr}; br_e=1 redirects fetch to br_addr
//   inst_sram_en       SRAM read enable (data returns the following cycle)
//   inst_sram_wen      always 4'b0 (fetch never writes)
//   inst_sram_addr     fetch address
//   inst_sram_wdata    always 32'b0
//   inst_sram_rdata    SRAM read data
//   out_valid/ready    head-of-queue handshake towards ID
//   out_pc, out_inst   head entry contents
//   occupancy          number of queued entries (debug/perf)
//
// Handshake: an entry transfers to ID on every cycle in which out_valid and
// out_ready are both high at the rising edge.  out_valid never depends on
// out_ready; out_ready may depend on out_valid.
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [32:0]      br_bus,
  output logic             inst_sram_en,
  output logic [3:0]       inst_sram_wen,
  output logic [31:0]      inst_sram_addr,
  output logic [31:0]      inst_sram_wdata,
  input  logic [31:0]      inst_sram_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [PTR_W:0]   occupancy
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic             br_e;
  logic [31:0]      br_addr;
  assign {br_e, br_addr} = br_bus;

  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             drop_q, drop_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             pop;
  logic             push;
  logic             issue;
  logic [PTR_W+1:0] demand;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  // Slots already promised: queued entries plus the read on its way back,
  // less the entry leaving this cycle.  Keeping this below DEPTH guarantees
  // every issued read has a slot when it returns.
  assign demand = (PTR_W+2)'(count_q) + (PTR_W+2)'(inflight_q) - (PTR_W+2)'(pop);
  assign issue  = !rst && !br_e && (demand < (PTR_W+2)'(DEPTH));

  // The SRAM has a fixed one-cycle latency, so the word for an in-flight
  // read is on inst_sram_rdata in the same cycle inflight_q is high.  A
  // branch in that cycle suppresses the push directly; drop_q marks that
  // beat as discarded and clears on the following cycle.
  assign push = inflight_q && !drop_q && !br_e && !rst;

  assign inst_sram_en    = issue;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wen   = 4'b0;
  assign inst_sram_wdata = 32'b0;

  assign out_pc    = mem_q[rd_ptr_q].pc;
  assign out_inst  = mem_q[rd_ptr_q].inst;
  assign occupancy = count_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    drop_d        = 1'b0;
    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (br_e) begin
      // Flush: any pop this cycle is deliberately ignored; ID squashes its
      // own copy of the instruction.
      pc_d     = br_addr;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      drop_d   = inflight_q;
    end else begin
      if (issue) begin
        pc_d          = pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (push) begin
        mem_d[wr_ptr_q].pc   = inflight_pc_q;
        mem_d[wr_ptr_q].inst = inst_sram_rdata;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'b0;
      drop_q        <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
